// File: rtl/apb_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_spi_pkg
// Brief    : Shared FSM state encoding and default sizes for the APB-to-SPI
//            write buffer.
// Revision : 1.0
// ============================================================================
package apb_spi_pkg;

    localparam int c_DATA_W = 16;
    localparam int c_DEPTH  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } apb_state_t;

endpackage
`default_nettype wire

// File: rtl/apb_spi_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : apb_spi_sync_fifo
// Brief    : Single-clock TX FIFO with occupancy count; head word is visible
//            combinationally and reads as zero while empty.
// Revision : 1.0
// ============================================================================
module apb_spi_sync_fifo
    import apb_spi_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int DEPTH  = c_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic [DATA_W-1:0]            i_data,
    input  logic                         i_pop,
    output logic                         o_full,
    output logic                         o_valid,
    output logic [DATA_W-1:0]            o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_level
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = $clog2(DEPTH + 1);
    localparam logic [c_LVL_W-1:0] c_FULL_LVL = c_LVL_W'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_LVL_W-1:0] r_level;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_level == c_FULL_LVL);
    assign w_empty = (r_level == '0);
    assign w_push  = i_push & ~w_full;
    assign w_pop   = i_pop & ~w_empty;

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers are power-of-two wide, so the increment wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_full  = w_full;
    assign o_valid = ~w_empty;
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/apb_spi_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : apb_spi_write_buffer
// Brief    : APB write slave feeding a TX FIFO drained by an SPI engine.
//            Optional macro APB_WBUF_PSLVERR_EN adds PSLVERR and turns a
//            full-FIFO write into a dropped, error-flagged transfer.
// Revision : 1.0
// ============================================================================
module apb_spi_write_buffer
    import apb_spi_pkg::*;
#(
    parameter int DATA_W = c_DATA_W,
    parameter int DEPTH  = c_DEPTH
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         IO_reg,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [DATA_W-1:0]            PWDATA,
    output logic                         PREADY_W,
    output logic                         SPI_send,
    output logic [DATA_W-1:0]            SPI_data,
    input  logic                         SPI_ack,
    output logic [$clog2(DEPTH+1)-1:0]   LEVEL
`ifdef APB_WBUF_PSLVERR_EN
    ,
    output logic                         PSLVERR
`endif
);

    apb_state_t r_state;
    logic       r_pready;
    logic       w_full;
    logic       w_access;
    logic       w_push;

`ifdef APB_WBUF_PSLVERR_EN
    logic       r_slverr;
    assign PSLVERR = r_slverr;
`endif

    assign w_access = (r_state == ACCESS) & PSEL & PENABLE;
    assign w_push   = w_access & ~w_full & ~PRESET;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state  <= IDLE;
            r_pready <= 1'b0;
`ifdef APB_WBUF_PSLVERR_EN
            r_slverr <= 1'b0;
`endif
        end else begin
            r_pready <= 1'b0;
`ifdef APB_WBUF_PSLVERR_EN
            r_slverr <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (PSEL && !PENABLE && PWRITE && IO_reg) begin
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!PSEL) begin
                        r_state <= IDLE;
                    end else if (PENABLE) begin
                        // Full is judged on the pre-pop level; a same-cycle pop
                        // lets the push land on the following edge.
                        if (!w_full) begin
                            r_state  <= RESP;
                            r_pready <= 1'b1;
                        end
`ifdef APB_WBUF_PSLVERR_EN
                        else begin
                            r_state  <= RESP;
                            r_pready <= 1'b1;
                            r_slverr <= 1'b1;
                        end
`endif
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign PREADY_W = r_pready;

    apb_spi_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (PCLK),
        .rst     (PRESET),
        .i_push  (w_push),
        .i_data  (PWDATA),
        .i_pop   (SPI_ack),
        .o_full  (w_full),
        .o_valid (SPI_send),
        .o_data  (SPI_data),
        .o_level (LEVEL)
    );

endmodule
`default_nettype wire

// File: tb/tb_apb_spi_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_spi_write_buffer
// Brief    : Directed, table-driven bench for apb_spi_write_buffer.
// Revision : 1.0
// ============================================================================
module tb_apb_spi_write_buffer;

    logic        PCLK = 1'b0;
    logic        PRESET, IO_reg, PSEL, PENABLE, PWRITE, SPI_ack;
    logic [15:0] PWDATA;
    logic        PREADY_W, SPI_send;
    logic [15:0] SPI_data;
    logic [2:0]  LEVEL;
`ifdef APB_WBUF_PSLVERR_EN
    logic        PSLVERR;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] exp_q[$];

    always #5 PCLK = ~PCLK;

    apb_spi_write_buffer #(.DATA_W(16), .DEPTH(4)) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .IO_reg   (IO_reg),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PREADY_W (PREADY_W),
        .SPI_send (SPI_send),
        .SPI_data (SPI_data),
        .SPI_ack  (SPI_ack),
        .LEVEL    (LEVEL)
`ifdef APB_WBUF_PSLVERR_EN
        ,
        .PSLVERR  (PSLVERR)
`endif
    );

    typedef struct {
        logic        rst, psel, pen, pwr, io, ack;
        logic [15:0] wdata;
        logic        exp_pready, exp_send;
        logic [15:0] exp_data;
        logic [2:0]  exp_level;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic psel, logic pen, logic pwr, logic io,
                                logic ack, logic [15:0] wd, logic rdy, logic snd,
                                logic [15:0] dat, logic [2:0] lvl);
        vec_t v;
        v.rst = rst; v.psel = psel; v.pen = pen; v.pwr = pwr; v.io = io; v.ack = ack;
        v.wdata = wd; v.exp_pready = rdy; v.exp_send = snd; v.exp_data = dat;
        v.exp_level = lvl;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic do_reset();
        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; SPI_ack = 1'b0;
        tick();
        PRESET = 1'b0;
        exp_q.delete();
    endtask

    // Full APB write (setup, access, response) into a non-full FIFO.
    task automatic apb_write(input logic [15:0] d, input logic ack_in);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; IO_reg = 1'b1; PWDATA = d; SPI_ack = 1'b0;
        tick();
        PENABLE = 1'b1;
        SPI_ack = ack_in;
        if (ack_in) begin
            check("wr_head", 32'(SPI_data), 32'(exp_q[0]));
            void'(exp_q.pop_front());
        end
        exp_q.push_back(d);
        tick();
        check("wr_pready", 32'(PREADY_W), 32'd1);
        check("wr_level", 32'(LEVEL), 32'(exp_q.size()));
        SPI_ack = 1'b0;
        tick();
        check("wr_t3_pready", 32'(PREADY_W), 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            check("drain_send", 32'(SPI_send), 32'd1);
            check("drain_data", 32'(SPI_data), 32'(exp_q[0]));
            SPI_ack = 1'b1;
            tick();
            void'(exp_q.pop_front());
        end
        SPI_ack = 1'b0;
        check("drain_level", 32'(LEVEL), 32'(exp_q.size()));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESET = 1'b1; IO_reg = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        SPI_ack = 1'b0; PWDATA = '0;

        //                rst psel pen pwr io ack wdata    rdy snd data     lvl
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 3'd0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 3'd0));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 16'hA5A5, 0, 0, 16'h0000, 3'd0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 0, 16'hA5A5, 1, 1, 16'hA5A5, 3'd1));
        vecs.push_back(mk(0, 1, 1, 1, 1, 0, 16'hA5A5, 0, 1, 16'hA5A5, 3'd1));
        vecs.push_back(mk(0, 1, 0, 0, 1, 0, 16'h0000, 0, 1, 16'hA5A5, 3'd1));
        vecs.push_back(mk(0, 1, 1, 0, 1, 0, 16'h0000, 0, 1, 16'hA5A5, 3'd1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 16'h1234, 0, 1, 16'hA5A5, 3'd1));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 16'h1234, 0, 1, 16'hA5A5, 3'd1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 1, 16'hA5A5, 3'd1));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 16'hBEEF, 0, 1, 16'hA5A5, 3'd1));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 16'hBEEF, 0, 1, 16'hA5A5, 3'd1));
        vecs.push_back(mk(0, 1, 1, 1, 1, 0, 16'hBEEF, 0, 1, 16'hA5A5, 3'd1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 16'h0000, 0, 1, 16'hA5A5, 3'd1));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 16'h1111, 0, 1, 16'hA5A5, 3'd1));
        vecs.push_back(mk(0, 1, 1, 1, 1, 0, 16'h1111, 1, 1, 16'hA5A5, 3'd2));
        vecs.push_back(mk(0, 1, 1, 1, 1, 0, 16'h1111, 0, 1, 16'hA5A5, 3'd2));
        vecs.push_back(mk(0, 1, 0, 1, 1, 0, 16'h2222, 0, 1, 16'hA5A5, 3'd2));
        vecs.push_back(mk(0, 1, 1, 1, 1, 1, 16'h2222, 1, 1, 16'h1111, 3'd2));
        vecs.push_back(mk(0, 1, 1, 1, 1, 0, 16'h2222, 0, 1, 16'h1111, 3'd2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 16'h0000, 0, 1, 16'h2222, 3'd1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 16'h0000, 3'd0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 16'h0000, 3'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            PRESET = vecs[i].rst; PSEL = vecs[i].psel; PENABLE = vecs[i].pen;
            PWRITE = vecs[i].pwr; IO_reg = vecs[i].io; SPI_ack = vecs[i].ack;
            PWDATA = vecs[i].wdata;
            tick();
            check($sformatf("v%0d_pready", i), 32'(PREADY_W), 32'(vecs[i].exp_pready));
            check($sformatf("v%0d_send", i), 32'(SPI_send), 32'(vecs[i].exp_send));
            check($sformatf("v%0d_data", i), 32'(SPI_data), 32'(vecs[i].exp_data));
            check($sformatf("v%0d_level", i), 32'(LEVEL), 32'(vecs[i].exp_level));
        end
        SPI_ack = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;

`ifndef APB_WBUF_PSLVERR_EN
        // Fifth write into a full FIFO waits until one word is popped.
        do_reset();
        for (int i = 1; i <= 4; i++) apb_write(16'(i), 1'b0);
        check("full_level", 32'(LEVEL), 32'd4);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; IO_reg = 1'b1; PWDATA = 16'h0005;
        tick();
        PENABLE = 1'b1;
        tick();
        check("full_wait1_pready", 32'(PREADY_W), 32'd0);
        check("full_wait1_level", 32'(LEVEL), 32'd4);
        tick();
        check("full_wait2_pready", 32'(PREADY_W), 32'd0);
        check("full_head", 32'(SPI_data), 32'h0001);
        SPI_ack = 1'b1;
        tick();
        void'(exp_q.pop_front());
        check("full_pop_level", 32'(LEVEL), 32'd3);
        check("full_pop_pready", 32'(PREADY_W), 32'd0);
        check("full_pop_head", 32'(SPI_data), 32'h0002);
        SPI_ack = 1'b0;
        tick();
        exp_q.push_back(16'h0005);
        check("full_done_pready", 32'(PREADY_W), 32'd1);
        check("full_done_level", 32'(LEVEL), 32'd4);
        tick();
        check("full_t3_pready", 32'(PREADY_W), 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        drain(4);
`else
        // Full FIFO with error reporting: word dropped, single error response.
        do_reset();
        check("slverr_rst", 32'(PSLVERR), 32'd0);
        for (int i = 1; i <= 4; i++) apb_write(16'(i), 1'b0);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; IO_reg = 1'b1; PWDATA = 16'hDEAD;
        tick();
        check("slverr_setup", 32'(PSLVERR), 32'd0);
        PENABLE = 1'b1;
        tick();
        check("slverr_pready", 32'(PREADY_W), 32'd1);
        check("slverr_flag", 32'(PSLVERR), 32'd1);
        check("slverr_level", 32'(LEVEL), 32'd4);
        tick();
        check("slverr_t3_pready", 32'(PREADY_W), 32'd0);
        check("slverr_t3_flag", 32'(PSLVERR), 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        drain(4);
`endif

        // Push with concurrent pop at LEVEL=2, across several pointer wraps.
        do_reset();
        apb_write(16'h0100, 1'b0);
        apb_write(16'h0101, 1'b0);
        for (int i = 0; i < 10; i++) apb_write(16'h0200 + 16'(i), 1'b1);
        drain(2);

        // Reset in the middle of a transfer with three words buffered.
        do_reset();
        for (int i = 0; i < 3; i++) apb_write(16'h0300 + 16'(i), 1'b0);
        check("rst_pre_level", 32'(LEVEL), 32'd3);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; IO_reg = 1'b1; PWDATA = 16'h0399;
        tick();
        PENABLE = 1'b1; PRESET = 1'b1;
        tick();
        check("rst_level", 32'(LEVEL), 32'd0);
        check("rst_send", 32'(SPI_send), 32'd0);
        check("rst_pready", 32'(PREADY_W), 32'd0);
        check("rst_data", 32'(SPI_data), 32'd0);
        PRESET = 1'b0;
        tick();
        check("rst_after_level", 32'(LEVEL), 32'd0);
        check("rst_after_pready", 32'(PREADY_W), 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        exp_q.delete();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_spi_write_buffer.md
APB_SPI_WRITE_BUFFER -- requirements
Module: apb_spi_write_buffer

Interface
REQ-001 Parameter DATA_W, default 16, width of PWDATA and SPI_data.
REQ-002 Parameter DEPTH, default 4, TX FIFO entries; power of two, >=2.
REQ-003 PCLK  in  1  sole clock; all state updates on rising edge.
REQ-004 PRESET  in  1  synchronous, active-high reset.
REQ-005 IO_reg  in  1  address decode: high when the APB address selects the TX data register.
REQ-006 PSEL, PENABLE, PWRITE  in  1 each  APB control.
REQ-007 PWDATA  in  DATA_W  APB write data.
REQ-008 PREADY_W  out  1  registered APB ready for write transfers.
REQ-009 SPI_send  out  1  valid: FIFO holds at least one word.
REQ-010 SPI_data  out  DATA_W  FIFO head word, stable while SPI_send high and SPI_ack low.
REQ-011 SPI_ack  in  1  ready from SPI engine; pops the head word when SPI_send is also high.
REQ-012 LEVEL  out  $clog2(DEPTH+1)  current FIFO occupancy.

Function
REQ-013 FSM states SHALL be IDLE, ACCESS, RESP.
REQ-014 IDLE->ACCESS when PSEL & !PENABLE & PWRITE & IO_reg (setup phase T1).
REQ-015 In ACCESS with PSEL & PENABLE and LEVEL<DEPTH: push PWDATA at that edge, set PREADY_W=1, go to RESP.
REQ-016 In ACCESS with LEVEL==DEPTH: no push, PREADY_W stays 0, remain in ACCESS (wait states).
REQ-017 RESP: PREADY_W high for exactly one cycle, then IDLE with PREADY_W=0.
REQ-018 Minimum write latency: T1 setup, T2 push, T3 PREADY_W=1; transfer completes at end of T3.
REQ-019 PSEL deasserted in ACCESS (abort): go to IDLE, no push, PREADY_W stays 0.
REQ-020 Non-TX accesses (IO_reg=0 or PWRITE=0) SHALL leave the FSM in IDLE and PREADY_W at 0.
REQ-021 Exactly one push per APB transfer, regardless of wait-state count.
REQ-022 Pop when SPI_send & SPI_ack; SPI_ack while empty is ignored.
REQ-023 Push into an empty FIFO: SPI_send and SPI_data valid the next cycle (one-cycle first-word latency).
REQ-024 Simultaneous push and pop with 0<LEVEL<DEPTH: LEVEL unchanged, order preserved.
REQ-025 Full decision uses LEVEL before the pop; pop in a full cycle lets the push proceed the following cycle.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH; LEVEL never exceeds DEPTH nor underflows.

Reset
REQ-027 PRESET high at a clock edge: FSM to IDLE, PREADY_W=0, pointers=0, LEVEL=0, SPI_send=0, SPI_data=0.
REQ-028 Reset mid-transfer or with FIFO non-empty SHALL discard all buffered words; no push completes in the reset cycle.

Configuration
REQ-029 Macro APB_WBUF_PSLVERR_EN, when defined, adds output PSLVERR (1 bit, reset 0).
REQ-030 With APB_WBUF_PSLVERR_EN: full in ACCESS -> no wait states; drop the word, go to RESP with PREADY_W=1 and PSLVERR=1 for that one cycle; PSLVERR=0 on all other cycles.
REQ-031 Without APB_WBUF_PSLVERR_EN: PSLVERR port absent; full behaviour per REQ-016.

Structure
REQ-032 Shared package apb_spi_pkg holds the FSM state enum and DEPTH/DATA_W default constants.
REQ-033 FIFO storage, pointers and LEVEL SHALL live in sub-module apb_spi_sync_fifo; the top holds the FSM and APB logic.

Verification
REQ-034 Single write 0xA5A5 to empty FIFO, SPI_ack=0 -> PREADY_W=1 in T3, LEVEL=1, SPI_send=1, SPI_data=0xA5A5 from cycle after T2.
REQ-035 Four back-to-back writes 0x0001..0x0004, SPI_ack=0, then fifth write 0x0005 -> fifth PREADY_W stays 0; raising SPI_ack one cycle pops 0x0001, fifth completes one cycle later, drain order 0x0002..0x0005.
REQ-036 With APB_WBUF_PSLVERR_EN, full FIFO, write 0xDEAD -> PREADY_W=1 and PSLVERR=1 in T3, LEVEL stays 4, 0xDEAD never appears on SPI_data.
REQ-037 LEVEL=2 with SPI_ack held high during a push -> LEVEL stays 2 that cycle, data order preserved across pointer wrap after 10 words.
REQ-038 PSEL dropped in ACCESS -> no push, PREADY_W=0; PRESET pulse with LEVEL=3 -> next cycle LEVEL=0, SPI_send=0, PREADY_W=0.
REQ-039 Read transfer (PWRITE=0) and write with IO_reg=0 -> PREADY_W stays 0, LEVEL unchanged.
